uart_tx: RTL
============

# uart_tx

UART transmitter, the return path of the serial link. It accepts bytes over a valid/ready handshake, serialises them LSB-first on `out` with start bit, optional parity and 1 or 2 stop bits, and signals frame completion. It is a client of the shared configuration bus (`c_valid`/`c_addr`/`c_data`/`c_ready`), through which the configuration manager sets baud rate and frame format, and runs entirely in the UART clock domain.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, input clock frequency; bit period `DIV` = `CLK_FREQ_HZ / baud`, truncated.
- `clk` in 1: UART clock; single clock for the whole block.
- `rst_n` in 1: synchronous, active-low reset.
- `c_valid` in 1: configuration write strobe.
- `c_addr` in 4: configuration register address.
- `c_data` in 8: configuration write data.
- `c_ready` out 1: block idle and able to take configuration.
- `data` in 8: byte to transmit.
- `valid` in 1: `data` is valid.
- `ready` out 1: byte accepted on `valid & ready`.
- `out` out 1: serial line, idle high.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- Config registers, write takes effect when `c_valid & c_ready` and the address matches.
  - Address 4'h2, `baud_sel` = `c_data[2:0]`: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200. Codes 5–7 are ignored and the register holds its value. Reset value is 4.
  - Address 4'h3, `parity` = `c_data[1:0]`: 00 none, 01 even, 10 odd, 11 none. `stop2` = `c_data[2]`. Reset values are 00 and 0.
  - All other addresses are ignored.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: `ready`=1, `c_ready`=1, `out`=1. On `valid`, latch `data`, `DIV`, `parity` and `stop2`, then go to START.
  - START: `out`=0 for `DIV` cycles.
  - DATA: bits 0..7 in order, each held `DIV` cycles. A 3-bit counter counts the bits; after bit 7 go to PARITY if parity is enabled, else to STOP.
  - PARITY: even parity bit = `^data`, odd parity bit = `~^data`. Held `DIV` cycles.
  - STOP: `out`=1 for `DIV` cycles, or 2×`DIV` cycles if `stop2`.
- `busy` = (state != IDLE).
- `done` is asserted in the first IDLE cycle after STOP.
- Baud counter: 16 bits, counts 0..`DIV`−1 and restarts on every state entry.
- Config write and byte accept in the same cycle: the frame uses the old settings; the new settings apply from the next frame.
- `valid` while not ready: the byte is held off and no data is lost.

## Timing
- Reset values: `out`=1, `ready`=1, `c_ready`=1, `busy`=0, `done`=0. Config registers return to defaults.
- Reset mid-frame: `out`=1 after the reset edge, the frame is aborted, and no `done` is issued.
- `out` is registered. A byte accepted at edge k drives `out`=0 from edge k+1.
- Frame length N = 1 + 8 + p + s bits, where p is 1 if parity is enabled (else 0) and s is the number of stop bits. `done` is high in the cycle after edge k+1+N·`DIV`.
- Back-to-back: a new byte can be accepted in the `done` cycle. The minimum inter-frame idle is then 1 cycle of `out`=1 beyond the stop bit(s).
- `c_ready` drops in the cycle after acceptance and returns with `done`.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and `parity` register exist as above.
- `UART_TX_PARITY_EN` undefined:
  - the PARITY state and `parity` register are removed;
  - writes to `c_data[1:0]` at 4'h3 are ignored, and only `stop2` is kept;
  - frames are always 8N1 or 8N2.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding;
  - config addresses 4'h2 and 4'h3;
  - baud-select codes;
  - the function mapping `baud_sel` to `DIV` from `CLK_FREQ_HZ`.
- Sub-module `uart_baud_tick`: a restartable 16-bit counter that emits a one-cycle tick every `DIV` cycles. It is shared with the receiver.

## Test plan
All scenarios run with `CLK_FREQ_HZ`=1_152_000, which gives `DIV`=10 at `baud_sel`=4.
- Reset, then send 8'hA5 at 8N1 → `out` shows the sequence 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles. `done` is high in the cycle after edge k+101. `busy` is high throughout the frame.
- Write 4'h3 = 8'h01 (even parity), send 8'h07 → parity bit 1 and frame length 110 cycles. Write 8'h02 (odd parity), send 8'h07 → parity bit 0.
- Write 4'h3 = 8'h04 (stop2), send 8'hFF → stop level held 20 cycles and `done` in the cycle after edge k+111. Write 4'h2 = 8'h07 → `baud_sel` stays 4.
- `valid` held high with bytes 8'h11, 8'h22 → the second byte is accepted in the `done` cycle of the first, with exactly one extra high cycle between the frames.
- Config write of `baud_sel`=3 in the same cycle as accepting 8'h55 → the 8'h55 frame uses `DIV`=10. The next frame uses `DIV`=20 (1_152_000/57600). `c_valid` during a frame has no effect.
- Assert `rst_n`=0 during DATA bit 3 → `out`=1 the next cycle, no `done` pulse, and `parity`/`stop2` return to defaults.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM encoding, config addresses,
//               baud-select codes and the baud_sel -> DIV mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_start  = 3'd1;
    localparam state_t c_st_data   = 3'd2;
    localparam state_t c_st_parity = 3'd3;
    localparam state_t c_st_stop   = 3'd4;

    localparam logic [3:0] c_cfg_addr_baud  = 4'h2;
    localparam logic [3:0] c_cfg_addr_frame = 4'h3;

    localparam logic [2:0] c_baud_9600   = 3'd0;
    localparam logic [2:0] c_baud_19200  = 3'd1;
    localparam logic [2:0] c_baud_38400  = 3'd2;
    localparam logic [2:0] c_baud_57600  = 3'd3;
    localparam logic [2:0] c_baud_115200 = 3'd4;

    localparam logic [1:0] c_par_even = 2'b01;
    localparam logic [1:0] c_par_odd  = 2'b10;

    // Divisors are constant per code, so this folds to a small lookup.
    function automatic logic [15:0] baud_div(input logic [2:0] sel, input int unsigned clk_hz);
        logic [31:0] v_div;
        case (sel)
            c_baud_9600:  v_div = clk_hz / 32'd9600;
            c_baud_19200: v_div = clk_hz / 32'd19200;
            c_baud_38400: v_div = clk_hz / 32'd38400;
            c_baud_57600: v_div = clk_hz / 32'd57600;
            default:      v_div = clk_hz / 32'd115200;
        endcase
        return v_div[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Config bus, byte handshake and serial/status lines of uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;

    logic       c_valid;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       busy;
    logic       done;

    modport slave (
        input  c_valid, c_addr, c_data, data, valid,
        output c_ready, ready, out, busy, done
    );

    modport master (
        output c_valid, c_addr, c_data, data, valid,
        input  c_ready, ready, out, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Restartable 16-bit counter, one-cycle tick every i_div cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        i_restart,
    input  wire [15:0] i_div,
    output logic       o_tick
);

    logic [15:0] r_cnt;
    logic        w_last;

    assign w_last = (r_cnt == (i_div - 16'd1));
    assign o_tick = w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8 data bits LSB-first, 1/2 stop bits.
//               Parity support is built only with UART_TX_PARITY_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input wire        clk,
    input wire        rst_n,
    uart_tx_if.slave  bus
);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_next;
    logic        r_out;
    logic        w_out_next;
    logic        r_done;
    logic        w_done_next;
    logic [7:0]  r_data;
    logic [15:0] r_div;
    logic        r_stop2_lat;
    logic [2:0]  r_baud_sel;
    logic        r_stop2;
    logic        w_idle;
    logic        w_accept;
    logic        w_cfg_we;
    logic        w_tick;
    logic        w_restart;
    logic        w_unused_cfg;

`ifdef UART_TX_PARITY_EN
    logic [1:0]  r_parity;
    logic [1:0]  r_par_lat;
    logic        w_par_on;
    logic        w_par_bit;

    assign w_par_on  = (r_par_lat == c_par_even) || (r_par_lat == c_par_odd);
    assign w_par_bit = (r_par_lat == c_par_odd) ? ~^r_data : ^r_data;
`endif

    assign w_idle       = (r_state == c_st_idle);
    assign w_accept     = w_idle && bus.valid;
    assign w_cfg_we     = w_idle && bus.c_valid;
    assign w_unused_cfg = ^bus.c_data[7:3];

    assign bus.ready   = w_idle;
    assign bus.c_ready = w_idle;
    assign bus.busy    = !w_idle;
    assign bus.out     = r_out;
    assign bus.done    = r_done;

    // Counter held at zero while idle; every state change coincides with a wrap.
    assign w_restart = w_idle || (w_state_next != r_state);

    uart_baud_tick u_baud_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .i_div     (r_div),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud_sel <= c_baud_115200;
            r_stop2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 2'b00;
`endif
        end else if (w_cfg_we) begin
            if ((bus.c_addr == c_cfg_addr_baud) && (bus.c_data[2:0] <= c_baud_115200)) begin
                r_baud_sel <= bus.c_data[2:0];
            end
            if (bus.c_addr == c_cfg_addr_frame) begin
                r_stop2  <= bus.c_data[2];
`ifdef UART_TX_PARITY_EN
                r_parity <= bus.c_data[1:0];
`endif
            end
        end
    end

    // Frame settings are frozen at acceptance so config writes apply to the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= 8'h00;
            r_div       <= 16'd1;
            r_stop2_lat <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_lat   <= 2'b00;
`endif
        end else if (w_accept) begin
            r_data      <= bus.data;
            r_div       <= baud_div(r_baud_sel, CLK_FREQ_HZ);
            r_stop2_lat <= r_stop2;
`ifdef UART_TX_PARITY_EN
            r_par_lat   <= r_parity;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= 3'd0;
            r_out     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_out     <= w_out_next;
            r_done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_done_next    = 1'b0;
        w_out_next     = 1'b1;
        case (r_state)
            c_st_idle: begin
                w_bit_cnt_next = 3'd0;
                if (bus.valid) begin
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                if (w_tick) begin
                    w_state_next = c_st_data;
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = w_par_on ? c_st_parity : c_st_stop;
`else
                        w_state_next = c_st_stop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_st_parity: begin
                if (w_tick) begin
                    w_state_next = c_st_stop;
                end
            end
`endif
            c_st_stop: begin
                // Bit counter wrapped to 0 after data; reused to count the second stop bit.
                if (w_tick) begin
                    if (r_stop2_lat && (r_bit_cnt == 3'd0)) begin
                        w_bit_cnt_next = 3'd1;
                    end else begin
                        w_state_next = c_st_idle;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase

        case (w_state_next)
            c_st_start:  w_out_next = 1'b0;
            c_st_data:   w_out_next = r_data[w_bit_cnt_next];
`ifdef UART_TX_PARITY_EN
            c_st_parity: w_out_next = w_par_bit;
`endif
            default:     w_out_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
